// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register-file dump streamer.
package reg_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEF   = 8'hA5;
  localparam int         DATA_W_DEF     = 32;
  localparam int         BYTES_PER_WORD = DATA_W_DEF / 8;

  // Counter width that stays legal when a word is a single byte.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_dump_tx.sv
// Walks the integer register file and streams a header byte followed by every
// register, little-endian, to a valid/ready byte sink such as uart_tx.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int         NUM_REGS = 32,
  parameter int         ADDR_W   = 5,
  parameter int         DATA_W   = DATA_W_DEF,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int BPW = DATA_W / 8;
  localparam int BCW = cnt_width(BPW);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   reg_idx_q, reg_idx_d;
  logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;

  logic xfer;
  logic last_byte;
  logic last_reg;

  assign xfer      = tx_valid & tx_ready;
  assign last_byte = (byte_cnt_q == BCW'(BPW - 1));
  assign last_reg  = (reg_idx_q == ADDR_W'(NUM_REGS - 1));

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HDR;
          reg_idx_d = '0;
        end
      end
      ST_HDR: begin
        if (xfer) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d    = rdata;
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          shift_d    = shift_q >> 8;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          // Terminal check precedes the index increment, so reg_idx never wraps.
          if (last_byte) begin
            if (last_reg) begin
              state_d = ST_DONE;
            end else begin
              reg_idx_d = reg_idx_q + ADDR_W'(1);
              state_d   = ST_LOAD;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      reg_idx_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign raddr    = reg_idx_q;
  assign tx_valid = (state_q == ST_HDR) || (state_q == ST_SEND);
  assign tx_data  = (state_q == ST_HDR)  ? HDR_BYTE :
                    (state_q == ST_SEND) ? shift_q[7:0] : 8'h00;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_dump_tx.sv
// Randomized scoreboard bench for reg_dump_tx with a behavioural register file.
module tb_reg_dump_tx;

  localparam int NREG  = 32;
  localparam int FRAME = 1 + NREG * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] rf [NREG];
  logic [31:0] img [NREG];

  logic [7:0]  exp_q [$];
  logic [7:0]  rx_log [$];
  int          frame_bytes = 0;
  int          done_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          rmode = 0;
  bit          hold_prev = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  assign rdata = (raddr == 5'd0) ? 32'h0 : rf[raddr];

  reg_dump_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .raddr    (raddr),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // tx_ready stall model: 0 = always ready, 1 = 30% ready, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 99) < 30);
      default: tx_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        vectors++;
        if (!(tx_valid === 1'b1 && tx_data === hold_data)) begin
          miscompares++;
          $display("FAIL hold_stable: got valid=%0b data=%02h, required valid=1 data=%02h",
                   tx_valid, tx_data, hold_data);
        end
      end
      if (tx_valid && tx_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, required no transfer", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            miscompares++;
            $display("FAIL stream_byte[%0d]: got %02h, required %02h", frame_bytes, tx_data, e);
          end
        end
        rx_log.push_back(tx_data);
        frame_bytes++;
      end
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference frame: header then each register's bytes, least significant first.
  task automatic new_frame();
    rx_log.delete();
    frame_bytes = 0;
    done_cnt = 0;
    exp_q.push_back(8'hA5);
    for (int r = 0; r < NREG; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'((img[r] >> (8 * b)) & 32'hFF));
  endtask

  task automatic snap_image();
    for (int r = 0; r < NREG; r++) img[r] = (r == 0) ? 32'h0 : rf[r];
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // poke: 0 none, 1 restart attempts, 2 write x5 at reg 3, 3 stop in SEND at reg 7
  task automatic wait_done(input int budget, input int poke, output int cyc_done);
    int cyc;
    bit got, poked, wrote, stop;
    cyc = 1; got = 0; poked = 0; wrote = 0; stop = 0; cyc_done = -1;
    while (!got && !stop && cyc < budget) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        cyc_done = cyc;
        if (poke == 1) start = 1'b1;
      end else begin
        if (poke == 1 && !poked && frame_bytes >= 50) begin start = 1'b1; poked = 1; end
        if (poke == 2 && !wrote && raddr == 5'd3) begin rf[5] = 32'hCAFEF00D; wrote = 1; end
        if (poke == 3 && raddr == 5'd7 && tx_valid) stop = 1;
      end
      @(posedge clk); cyc++; #1 start = 1'b0;
    end
    if (!got && !stop) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_timeout: got no completion in %0d cycles, required completion", budget);
    end
  endtask

  task automatic post_frame(input string tag);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_queue_left"}, exp_q.size(), 32'd0);
    check({tag, "_frame_len"}, rx_log.size(), FRAME);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
  endtask

  initial begin
    logic [7:0] head9 [9];
    logic [7:0] tail4 [4];
    logic [7:0] x5b [4];
    int cd;
    int bad;
    head9 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    tail4 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    x5b   = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};

    for (int r = 0; r < NREG; r++) rf[r] = $urandom;
    rf[0] = 32'h0;
    rf[1] = 32'h11223344;
    rf[31] = 32'hDEADBEEF;

    // Reset state
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: always-ready frame with fixed timing
    rmode = 0; tx_ready = 1'b1;
    snap_image(); new_frame();
    start_pulse();
    wait_done(5000, 0, cd);
    check("t1_done_cycle", cd, 32'd162);
    if (rx_log.size() >= FRAME) begin
      for (int i = 0; i < 9; i++) check($sformatf("t1_head%0d", i), rx_log[i], head9[i]);
      for (int i = 0; i < 4; i++) check($sformatf("t1_tail%0d", i), rx_log[FRAME - 4 + i], tail4[i]);
    end
    post_frame("t1");

    // 2: random backpressure, identical stream
    rmode = 1;
    snap_image(); new_frame();
    start_pulse();
    wait_done(5000, 0, cd);
    post_frame("t2");

    // 3: start while busy and in DONE is ignored
    rmode = 0;
    snap_image(); new_frame();
    start_pulse();
    wait_done(5000, 1, cd);
    post_frame("t3");
    check("t3_idle_valid", 32'(tx_valid), 32'd0);

    // 4: asynchronous reset in SEND at reg 7, then fresh frame
    snap_image(); new_frame();
    start_pulse();
    wait_done(5000, 3, cd);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t4_rst_valid", 32'(tx_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_raddr", 32'(raddr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    snap_image(); new_frame();
    start_pulse();
    wait_done(5000, 0, cd);
    if (rx_log.size() > 0) check("t4_first_hdr", rx_log[0], 32'hA5);
    post_frame("t4");

    // 5: long stall in HDR
    rmode = 2; tx_ready = 1'b0;
    snap_image(); new_frame();
    start_pulse();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'hA5)) bad++;
    end
    check("t5_hdr_held_bad_cycles", bad, 32'd0);
    rmode = 0;
    wait_done(5000, 0, cd);
    post_frame("t5");

    // 6: write to x5 while reg 3 is being read
    snap_image();
    img[5] = 32'hCAFEF00D;
    new_frame();
    start_pulse();
    wait_done(5000, 2, cd);
    if (rx_log.size() >= FRAME)
      for (int i = 0; i < 4; i++) check($sformatf("t6_x5_b%0d", i), rx_log[1 + 5 * 4 + i], x5b[i]);
    post_frame("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
